// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed NUM_DIGITS-digit seven-segment driver. A load strobe
//   captures a value into a display register. The scan logic then enables
//   one digit per refresh slot and drives that digit's segment pattern.
//
// Optional feature (compile-time macro SEVSEG_BCD_EN):
//   - Undefined: hex mode. Each nibble of value is shown as a hex digit.
//     busy is tied low.
//   - Defined: BCD mode. value[BIN_W-1:0] is unsigned binary. It is turned
//     into decimal digits by a sequential double-dabble, one bit per clock.
//
// Ports
//   clk    in   1             rising-edge clock
//   reset  in   1             synchronous, active-high reset
//   load   in   1             capture strobe; ignored while busy
//   value  in   4*NUM_DIGITS  hex nibbles (digit 0 = [3:0]) or binary [BIN_W-1:0]
//   dp     in   NUM_DIGITS    decimal-point enables, captured with value
//   seg    out  8             seg[0]=a .. seg[6]=g, seg[7]=dp, active-high
//   an     out  NUM_DIGITS    one-hot digit enable, bit0 = rightmost digit
//   busy   out  1             conversion in progress (BCD mode only)
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BIN_W       = 13
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    busy
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [VAL_W-1:0]      disp_reg;
  logic [NUM_DIGITS-1:0] dp_reg;
  logic [CNT_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      digit_idx;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Scan: an/seg are registered from the index held before this edge.
  // The index therefore changes one edge before the outputs follow it,
  // and every digit stays lit for exactly REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      seg         <= '0;
      an          <= '0;
    end else begin
      an  <= NUM_DIGITS'(1) << digit_idx;
      seg <= {dp_reg[digit_idx], glyph(disp_reg[{digit_idx, 2'b00} +: 4])};
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

`ifdef SEVSEG_BCD_EN

  typedef enum logic {IDLE, CONV} state_t;

  localparam int BCNT_W = $clog2(BIN_W + 1);

  state_t                state;
  logic [BIN_W-1:0]      operand;
  logic [VAL_W-1:0]      bcd;
  logic [VAL_W-1:0]      bcd_next;
  logic [NUM_DIGITS-1:0] dp_pend;
  logic [BCNT_W-1:0]     bit_cnt;

  // One double-dabble iteration. Each BCD nibble >= 5 gets 3 added first,
  // then the vector shifts left by one and takes in the next operand bit.
  function automatic logic [VAL_W-1:0] dabble_step(input logic [VAL_W-1:0] cur,
                                                   input logic in_bit);
    logic [VAL_W-1:0] adj;
    adj = cur;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    dabble_step = {adj[VAL_W-2:0], in_bit};
  endfunction

  assign bcd_next = dabble_step(bcd, operand[BIN_W-1]);

  generate
    if (BIN_W < VAL_W) begin : g_unused_hi
      logic unused_value_hi;
      assign unused_value_hi = ^value[VAL_W-1:BIN_W];
    end
  endgenerate

  // Only the last CONV cycle writes disp_reg. The digits on the display
  // never show a partial conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      disp_reg <= '0;
      dp_reg   <= '0;
      operand  <= '0;
      bcd      <= '0;
      dp_pend  <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            operand <= value[BIN_W-1:0];
            dp_pend <= dp;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        default: begin
          operand <= operand << 1;
          bcd     <= bcd_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BCNT_W'(BIN_W - 1)) begin
            disp_reg <= bcd_next;
            dp_reg   <= dp_pend;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

`else

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_reg <= '0;
      dp_reg   <= '0;
    end else if (load) begin
      disp_reg <= value;
      dp_reg   <= dp;
    end
  end

  assign busy = 1'b0;

`endif

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Randomized testbench for seven_seg_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4).
// A behavioural model tracks which digit should be lit, from the cycle count
// since reset, and the value shown on the display. The same bench works for
// hex mode and for BCD mode (SEVSEG_BCD_EN).
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int BW = 13;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0] dp = '0;
  logic [7:0]   seg;
  logic [N-1:0] an;
  logic         busy;

  int total = 0;
  int bad   = 0;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BIN_W(BW)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp),
    .seg(seg), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] glyphs [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // model state
  int           t = 0;          // edges since reset release
  logic [4*N-1:0] m_disp = '0;
  logic [N-1:0] m_dp = '0;
  int           pending = 0;    // cycles left until a conversion lands
  logic [4*N-1:0] pend_val = '0;
  logic [N-1:0] pend_dp = '0;
  logic [7:0]   exp_seg = '0;
  logic [N-1:0] exp_an = '0;
  logic         exp_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic step(input logic r, input logic l, input logic [4*N-1:0] v, input logic [N-1:0] d);
    int dig;
    logic [3:0] nib;
    reset = r; load = l; value = v; dp = d;
    @(posedge clk);
    if (r) begin
      t = 0; m_disp = '0; m_dp = '0; pending = 0;
      exp_seg = '0; exp_an = '0;
    end else begin
      t++;
      dig = ((t - 1) / RD) % N;
      exp_an = N'(1) << dig;
      nib = 4'(m_disp >> (4 * dig));
      exp_seg = glyphs[nib] | (m_dp[dig] ? 8'h80 : 8'h00);
`ifdef SEVSEG_BCD_EN
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          m_disp = pend_val;
          m_dp = pend_dp;
        end
      end else if (l) begin
        pending = BW;
        pend_val = to_bcd(int'(v) % (1 << BW));
        pend_dp = d;
      end
`else
      if (l) begin
        m_disp = v;
        m_dp = d;
      end
`endif
    end
    exp_busy = (pending > 0);
    @(negedge clk);
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0);
    idle(10);
    step(1'b0, 1'b1, 16'h1234, 4'b0010);
    idle(20);
    step(1'b0, 1'b1, 16'h00C6, 4'b0000);
    idle(20);
    step(1'b0, 1'b1, 16'd198, 4'b0101);
    idle(4);
    step(1'b0, 1'b1, 16'd7, 4'b1111);
    idle(20);
    step(1'b0, 1'b1, 16'd8191, 4'b0000);
    idle(12);
    step(1'b0, 1'b1, 16'hE000, 4'b1000);  // load during or after busy window
    idle(20);
    step(1'b0, 1'b1, 16'd4321, 4'b0001);
    idle(5);
    step(1'b1, 1'b0, '0, '0);             // reset mid-conversion / mid-slot
    idle(20);
    for (int i = 0; i < 2500; i++)
      step(($urandom % 300) == 0, ($urandom % 6) == 0, $urandom, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
